// File: rtl/bcd_to_clock.sv
// Digit-entry front end: collects six BCD digits (HH MM SS), range-checks each one,
// and delivers binary hours/minutes/seconds with a one-cycle load strobe.
module bcd_to_clock #(
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic [3:0] i_digit,
  input  logic       i_digit_valid,
  input  logic       i_abort,
  output logic       o_ready,
  output logic [2:0] o_digit_index,
  output logic [4:0] o_hours,
  output logic [5:0] o_minutes,
  output logic [5:0] o_seconds,
  output logic       o_load,
  output logic       o_error
);

  typedef enum logic {
    StCollect,
    StCommit
  } state_e;

  localparam logic [23:0] TmoLimit = 24'(TIMEOUT_CYCLES);
  localparam bit          TmoEn    = (TIMEOUT_CYCLES != 0);

  state_e      r_state;
  logic [2:0]  r_idx;
  logic [3:0]  r_msd;
  logic [4:0]  r_stage_hours;
  logic [5:0]  r_stage_minutes;
  logic [23:0] r_tmo_cnt;
  logic [4:0]  r_hours;
  logic [5:0]  r_minutes;
  logic [5:0]  r_seconds;
  logic        r_load;
  logic        r_error;

  logic [3:0]  w_max_digit;
  logic [5:0]  w_pair;
  logic        w_collect;
  logic        w_abort;
  logic        w_timeout;
  logic        w_try;
  logic        w_legal;
  logic        w_accept;
  logic        w_reject;

  // Largest digit allowed at the current position; 10..15 always exceed it.
  always_comb begin
    w_max_digit = 4'd9;
    case (r_idx)
      3'd0:       w_max_digit = 4'd2;
      3'd1:       w_max_digit = (r_msd == 4'd2) ? 4'd3 : 4'd9;
      3'd2, 3'd4: w_max_digit = 4'd5;
      default:    w_max_digit = 4'd9;
    endcase
  end

  // msd*10 + lsd; legal pairs never exceed 59, so 6 bits is enough.
  assign w_pair = ({2'b00, r_msd} << 3) + ({2'b00, r_msd} << 1) + {2'b00, i_digit};

  assign w_collect = (r_state == StCollect);
  assign w_abort   = w_collect && i_abort;
  assign w_timeout = TmoEn && w_collect && !i_abort && (r_idx != 3'd0)
                     && (r_tmo_cnt == TmoLimit);
  assign w_try     = w_collect && !i_abort && !w_timeout && i_digit_valid;
  assign w_legal   = (i_digit <= w_max_digit);
  assign w_accept  = w_try && w_legal;
  assign w_reject  = w_try && !w_legal;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state         <= StCollect;
      r_idx           <= 3'd0;
      r_msd           <= 4'd0;
      r_stage_hours   <= 5'd0;
      r_stage_minutes <= 6'd0;
      r_tmo_cnt       <= 24'd0;
      r_hours         <= 5'd0;
      r_minutes       <= 6'd0;
      r_seconds       <= 6'd0;
      r_load          <= 1'b0;
      r_error         <= 1'b0;
    end else begin
      r_load  <= 1'b0;
      r_error <= w_reject || w_timeout;

      // Counts idle cycles only while a partial entry is pending.
      if (!TmoEn || !w_collect || (r_idx == 3'd0) || w_accept || w_abort || w_timeout) begin
        r_tmo_cnt <= 24'd0;
      end else begin
        r_tmo_cnt <= r_tmo_cnt + 24'd1;
      end

      if (r_state == StCommit) begin
        r_state <= StCollect;
        r_idx   <= 3'd0;
      end else if (w_abort || w_timeout) begin
        r_idx           <= 3'd0;
        r_msd           <= 4'd0;
        r_stage_hours   <= 5'd0;
        r_stage_minutes <= 6'd0;
      end else if (w_accept) begin
        case (r_idx)
          3'd0, 3'd2, 3'd4: begin
            r_msd <= i_digit;
            r_idx <= r_idx + 3'd1;
          end
          3'd1: begin
            r_stage_hours <= w_pair[4:0];
            r_idx         <= r_idx + 3'd1;
          end
          3'd3: begin
            r_stage_minutes <= w_pair;
            r_idx           <= r_idx + 3'd1;
          end
          3'd5: begin
            // Seconds go straight to the output; the index holds at 5 through COMMIT.
            r_hours   <= r_stage_hours;
            r_minutes <= r_stage_minutes;
            r_seconds <= w_pair;
            r_load    <= 1'b1;
            r_state   <= StCommit;
          end
          default: r_idx <= 3'd0;
        endcase
      end
    end
  end

  assign o_ready       = w_collect;
  assign o_digit_index = r_idx;
  assign o_hours       = r_hours;
  assign o_minutes     = r_minutes;
  assign o_seconds     = r_seconds;
  assign o_load        = r_load;
  assign o_error       = r_error;

endmodule

// File: tb/tb_bcd_to_clock.sv
// Bench for bcd_to_clock: a digit-level model checked every cycle, plus directed
// scenarios with literal expectations.
module tb_bcd_to_clock;

  localparam int unsigned Tmo = 100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] digit = 4'd0;
  logic       valid = 1'b0;
  logic       abort = 1'b0;
  logic       ready;
  logic [2:0] index;
  logic [4:0] hours;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic       load;
  logic       error;

  int n_cmp = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  bcd_to_clock #(.TIMEOUT_CYCLES(Tmo)) dut (
    .i_clk        (clk),
    .i_reset_n    (rst_n),
    .i_digit      (digit),
    .i_digit_valid(valid),
    .i_abort      (abort),
    .o_ready      (ready),
    .o_digit_index(index),
    .o_hours      (hours),
    .o_minutes    (minutes),
    .o_seconds    (seconds),
    .o_load       (load),
    .o_error      (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: the entry as a list of digits, committed time as plain integers.
  int m_pos = 0;
  int m_dig[6];
  bit m_commit = 0;
  int m_h = 0, m_m = 0, m_s = 0;
  bit m_load = 0, m_err = 0;
  int m_idle = 0;

  function automatic bit legal(input int pos, input int d, input int first);
    int lim;
    case (pos)
      0: lim = 2;
      1: lim = (first == 2) ? 3 : 9;
      2, 4: lim = 5;
      default: lim = 9;
    endcase
    return d <= lim;
  endfunction

  always @(posedge clk) begin
    bit acc;
    acc = 0;
    if (!rst_n) begin
      m_pos = 0; m_commit = 0; m_h = 0; m_m = 0; m_s = 0;
      m_load = 0; m_err = 0; m_idle = 0;
    end else if (m_commit) begin
      m_commit = 0; m_pos = 0; m_load = 0; m_err = 0; m_idle = 0;
    end else begin
      m_load = 0;
      m_err = 0;
      if (abort) begin
        m_pos = 0; m_idle = 0;
      end else if (m_pos > 0 && m_idle == Tmo) begin
        m_pos = 0; m_idle = 0; m_err = 1;
      end else begin
        if (valid) begin
          if (legal(m_pos, int'(digit), m_dig[0])) begin
            acc = 1;
            m_dig[m_pos] = int'(digit);
            if (m_pos == 5) begin
              m_commit = 1;
              m_load = 1;
              m_h = m_dig[0] * 10 + m_dig[1];
              m_m = m_dig[2] * 10 + m_dig[3];
              m_s = m_dig[4] * 10 + m_dig[5];
            end
          end else begin
            m_err = 1;
          end
        end
        if (acc || m_pos == 0) m_idle = 0;
        else m_idle++;
        if (acc && m_pos < 5) m_pos++;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("ready", int'(ready), int'(!m_commit));
      check("index", int'(index), m_pos);
      check("hours", int'(hours), m_h);
      check("minutes", int'(minutes), m_m);
      check("seconds", int'(seconds), m_s);
      check("load", int'(load), int'(m_load));
      check("error", int'(error), int'(m_err));
    end
  end

  task automatic send(input logic [3:0] d);
    @(posedge clk); #2;
    valid = 1'b1; digit = d; abort = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #2;
      valid = 1'b0; abort = 1'b0;
    end
  endtask

  task automatic do_abort();
    @(posedge clk); #2;
    valid = 1'b0; abort = 1'b1;
  endtask

  task automatic send6(input int a, b, c, d, e, f);
    send(4'(a)); send(4'(b)); send(4'(c)); send(4'(d)); send(4'(e)); send(4'(f));
  endtask

  initial begin
    int k;
    int errs;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    cmp_en = 1'b1;
    check("rst_ready", int'(ready), 1);
    check("rst_index", int'(index), 0);
    check("rst_hours", int'(hours), 0);
    check("rst_load", int'(load), 0);

    // 23:59:59
    send6(2, 3, 5, 9, 5, 9);
    idle(1);
    check("t1_load", int'(load), 1);
    check("t1_ready", int'(ready), 0);
    check("t1_hours", int'(hours), 23);
    check("t1_minutes", int'(minutes), 59);
    check("t1_seconds", int'(seconds), 59);
    idle(1);
    check("t1_ready_back", int'(ready), 1);
    check("t1_index_back", int'(index), 0);

    // Range rejections
    send(2); send(4); idle(1);
    check("t2_err_24", int'(error), 1);
    check("t2_idx_24", int'(index), 1);
    send(3); idle(1);
    check("t2_idx_23", int'(index), 2);
    check("t2_noerr_23", int'(error), 0);
    do_abort(); idle(1);
    check("t2_abort_idx", int'(index), 0);
    send(10); idle(1);
    check("t2_err_10", int'(error), 1);
    check("t2_idx_10", int'(index), 0);
    send(1); send(2); send(6); idle(1);
    check("t2_err_6", int'(error), 1);
    check("t2_idx_6", int'(index), 2);
    do_abort(); idle(1);

    // Abort together with a valid digit
    send(1); send(2); send(3);
    @(posedge clk); #2;
    valid = 1'b1; digit = 4'd4; abort = 1'b1;
    idle(1);
    check("t3_idx", int'(index), 0);
    check("t3_load", int'(load), 0);
    check("t3_err", int'(error), 0);
    check("t3_hours", int'(hours), 23);
    check("t3_minutes", int'(minutes), 59);
    check("t3_seconds", int'(seconds), 59);

    // Timeout after one digit
    send(1); idle(1);
    k = 0;
    for (int i = 1; i <= 200; i++) begin
      idle(1);
      if (error) begin
        k = i;
        break;
      end
    end
    check("t4_tmo_latency", k, 101);
    check("t4_tmo_idx", int'(index), 0);
    errs = 0;
    for (int i = 0; i < 1000; i++) begin
      idle(1);
      if (error) errs++;
    end
    check("t4_idle_errs", errs, 0);

    // Reset mid-entry
    send(0); send(9); send(0); send(5);
    @(posedge clk); #2;
    valid = 1'b0; rst_n = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    check("t5_rst_index", int'(index), 0);
    check("t5_rst_hours", int'(hours), 0);
    check("t5_rst_minutes", int'(minutes), 0);
    check("t5_rst_seconds", int'(seconds), 0);
    check("t5_rst_load", int'(load), 0);
    send6(0, 0, 0, 0, 0, 0); idle(1);
    check("t5_load", int'(load), 1);
    check("t5_hours", int'(hours), 0);
    idle(1);

    // Valid digit during COMMIT is ignored
    send6(0, 1, 0, 2, 0, 3);
    send(7);
    check("t6_commit_hours", int'(hours), 1);
    idle(1);
    check("t6_ignored_err", int'(error), 0);
    check("t6_ignored_idx", int'(index), 0);
    send6(1, 2, 3, 4, 5, 6); idle(1);
    check("t6_load", int'(load), 1);
    check("t6_hours", int'(hours), 12);
    check("t6_minutes", int'(minutes), 34);
    check("t6_seconds", int'(seconds), 56);
    idle(3);

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/bcd_to_clock.md
# bcd_to_clock

Digit-entry front end for setting the clock. It accepts BCD digits one at a time in display order: hours MSD, hours LSD, minutes MSD, minutes LSD, seconds MSD, seconds LSD. Each digit is range-checked and the pairs are assembled into binary hours, minutes and seconds. A one-cycle load strobe delivers the result to the time-keeping counters. This block performs the inverse of the binary-to-BCD digit multiplexer, and its `o_digit_index` numbering matches that multiplexer's segment-select numbering.

## Interface
- `TIMEOUT_CYCLES`, default 0: inactivity limit in clock cycles between accepted digits; 0 disables the timeout. Legal range 0 to 2^24-1.
- `i_clk`  input  1  system clock.
- `i_reset_n`  input  1  synchronous, active-low reset.
- `i_digit`  input  4  BCD digit value.
- `i_digit_valid`  input  1  `i_digit` is presented this cycle.
- `i_abort`  input  1  discard the partial entry and return to digit 0.
- `o_ready`  output  1  a digit can be accepted this cycle.
- `o_digit_index`  output  3  index of the next expected digit, 0 (hours MSD) to 5 (seconds LSD).
- `o_hours`  output  5  last committed hours, 0–23.
- `o_minutes`  output  6  last committed minutes, 0–59.
- `o_seconds`  output  6  last committed seconds, 0–59.
- `o_load`  output  1  one-cycle strobe; the `o_hours`/`o_minutes`/`o_seconds` values are new this cycle.
- `o_error`  output  1  one-cycle strobe; the previous-cycle digit was rejected or the entry timed out.

## Operation
- **States.** The block has two states, COLLECT and COMMIT.
  - `o_ready` is 1 in COLLECT and 0 in COMMIT.
- **Accept.** A digit is accepted when `i_digit_valid && o_ready && !i_abort` and the digit is legal for the current index:
  - idx0 (hours MSD): 0–2
  - idx1 (hours LSD): 0–9, or 0–3 if the staged hours MSD is 2
  - idx2 (minutes MSD), idx4 (seconds MSD): 0–5
  - idx1, idx3, idx5 (LSDs), other than the idx1 restriction above: 0–9
  - any value ≥ 10 is illegal at every index.
- **Accepted digit.**
  - On an MSD index, store the digit in the staging MSD register and increment the index.
  - On an LSD index, compute `msd*10 + lsd` as `(msd<<3) + (msd<<1) + lsd`, truncated to the field width, and store it in the staging hours, minutes or seconds register.
  - Then increment the index, except at idx5, where the block enters COMMIT.
- **Rejected digit.** A valid digit that is illegal for the current index:
  - `o_error` = 1 in the next cycle
  - index and staging registers unchanged
  - the user re-enters the same position.
- **COMMIT (one cycle).** The staging values are already copied to the output registers and `o_load` = 1. The index returns to 0 and the state returns to COLLECT on the next cycle.
- **Abort.** `i_abort` in COLLECT sets index to 0 and clears the staging registers. There is no `o_load` and no `o_error`; the output registers keep their values. `i_abort` together with `i_digit_valid`: abort wins and the digit is dropped. `i_abort` in COMMIT is ignored; the commit completes.
- **Timeout.** The timeout is active only when `TIMEOUT_CYCLES` > 0.
  - A counter clears on every accepted digit and whenever index = 0.
  - While index > 0 in COLLECT, the counter increments each cycle.
  - When it reaches `TIMEOUT_CYCLES`, the block behaves as an abort and also pulses `o_error` one cycle later.
  - Rejected digits do not clear the counter.
- **Outputs.** `o_hours`, `o_minutes` and `o_seconds` change only on commit or reset.

## Timing
- All outputs are registered.
- Reset values: `o_ready` = 1, `o_digit_index` = 0, `o_hours` = 0, `o_minutes` = 0, `o_seconds` = 0, `o_load` = 0, `o_error` = 0, state = COLLECT, staging = 0, timeout counter = 0.
- Reset mid-entry or during COMMIT takes priority over everything. No `o_load` is issued.
- Digit acceptance to index update: 1 cycle.
- The idx5 digit is accepted in cycle N. In cycle N+1, `o_load` = 1, the new time is on the outputs, and `o_ready` = 0. In cycle N+2, `o_ready` = 1 and `o_digit_index` = 0.
- A `i_digit_valid` presented during COMMIT is ignored with no error. The source must hold or re-present it.
- Back-to-back digits, one per cycle, are accepted. Six-digit entry minimum is 7 cycles to the commit return.
- `o_error` is asserted for exactly one cycle per rejected digit or timeout.

## Test plan
- Reset, then digits 2,3,5,9,5,9 on consecutive cycles -> `o_load` pulse with `o_hours`=23, `o_minutes`=59, `o_seconds`=59. `o_ready`=0 for that one cycle, then index=0.
- Digits 2 then 4 -> `o_error` pulse, index stays 1. Then digit 3 is accepted and index becomes 2. Digit 10 at idx0 -> error. Digit 6 at idx2 -> error.
- Digits 1,2,3 then `i_abort` asserted together with a valid 4 -> index=0, no `o_load`, outputs keep their prior values (e.g. 23:59:59 from the first test).
- `TIMEOUT_CYCLES`=100: digit 1, then idle -> `o_error` pulse and index=0 at 101–102 cycles after acceptance. With index=0 and idle for 1000 cycles -> no error.
- Digits 0,9,0,5 then `i_reset_n`=0 for one cycle -> all outputs at reset values. Then full entry 0,0,0,0,0,0 -> `o_load` with 00:00:00.
- Valid digit presented during the COMMIT cycle -> ignored, no error. The next entry 1,2,3,4,5,6 commits 12:34:56.
